// File: rtl/mix_ctrl_pkg.sv
// Shared constants, state encoding and width helper for the mix-layer sequencer.
package mix_ctrl_pkg;
  localparam int ROWS_DEF      = 16;
  localparam int HID_DIM_DEF   = 12;
  localparam int CHUNKS_DEF    = 2;
  localparam int BIAS_CAP0_DEF = 6;
  localparam int TMO_CYC_DEF   = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_PREFETCH, S_RUN, S_STORE, S_GAP, S_FIN
  } state_t;

  // Index width that stays legal for single-entry ranges.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mix_ctrl_addr.sv
// Run-cycle counter for the mix sequencer: derives weight address, segment select and
// bias address from the run index. Timeout tap is live only with MIX_CTRL_TIMEOUT_EN.
module mix_ctrl_addr import mix_ctrl_pkg::*; #(
  parameter int HID_DIM   = HID_DIM_DEF,
  parameter int CHUNKS    = CHUNKS_DEF,
  parameter int BIAS_CAP0 = BIAS_CAP0_DEF,
  parameter int TMO_CYC   = TMO_CYC_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       en,
  output logic [cw(HID_DIM*CHUNKS)-1:0] addr_w,
  output logic [cw(CHUNKS)-1:0]      seg_sel,
  output logic [cw(HID_DIM)-1:0]     addr_b,
  output logic                       tmo
);
  localparam int NW = HID_DIM * CHUNKS;
  localparam int AW = cw(NW);
  localparam int SW = cw(CHUNKS);
  localparam int BW = cw(HID_DIM);
  localparam int KW = cw(((TMO_CYC > NW) ? TMO_CYC : NW) + 1);

  logic [KW-1:0] k;
  logic [BW-1:0] b_q;
  int            ki, bi;

  // Saturates rather than wrapping so a stalled engine cannot restart the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              k <= '0;
    else if (load)           k <= '0;
    else if (en && k != '1)  k <= k + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_q <= '0;
    else        b_q <= addr_b;
  end

  // Address leads the run index by one to absorb the RAM read latency.
  always_comb begin
    ki      = int'(k);
    bi      = ki - (BIAS_CAP0 - 1);
    addr_w  = '0;
    if (en) addr_w = AW'((ki >= NW - 1) ? NW - 1 : ki + 1);
    seg_sel = SW'(((ki >= NW - 1) ? NW - 1 : ki) % CHUNKS);
    addr_b  = b_q;
    if (en && bi >= 0 && (bi % CHUNKS) == 0 && (bi / CHUNKS) < HID_DIM)
      addr_b = BW'(bi / CHUNKS);
  end

`ifdef MIX_CTRL_TIMEOUT_EN
  assign tmo = (k == KW'(TMO_CYC - 1));
`else
  assign tmo = 1'b0;
`endif
endmodule

// File: rtl/mix_ctrl.sv
// Mix-layer dot-product sequencer: per row PREFETCH, RUN until engine valid, STORE, GAP.
// Optional run timeout with sticky err enabled by MIX_CTRL_TIMEOUT_EN.
module mix_ctrl import mix_ctrl_pkg::*; #(
  parameter int ROWS      = ROWS_DEF,
  parameter int HID_DIM   = HID_DIM_DEF,
  parameter int CHUNKS    = CHUNKS_DEF,
  parameter int BIAS_CAP0 = BIAS_CAP0_DEF,
  parameter int TMO_CYC   = TMO_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          dot_run,
  input  logic                          dot_valid,
  output logic [cw(HID_DIM*CHUNKS)-1:0] addr_w,
  output logic [cw(CHUNKS)-1:0]         seg_sel,
  output logic [cw(HID_DIM)-1:0]        addr_b,
  output logic [cw(ROWS)-1:0]           d_row,
  output logic                          out_we,
  output logic [cw(ROWS)-1:0]           out_addr,
  output logic                          err
);
  localparam int RW = cw(ROWS);

  state_t state, state_nx;
  logic   row_clr, row_inc, cnt_load, tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       d_row <= '0;
    else if (row_clr) d_row <= '0;
    else if (row_inc) d_row <= d_row + 1'b1;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    dot_run  = 1'b0;
    out_we   = 1'b0;
    cnt_load = 1'b1;
    row_clr  = 1'b0;
    row_inc  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        row_clr  = 1'b1;
        state_nx = S_PREFETCH;
      end
      S_PREFETCH: state_nx = S_RUN;
      S_RUN: begin
        dot_run  = 1'b1;
        cnt_load = 1'b0;
        if (dot_valid) state_nx = S_STORE;
        else if (tmo)  state_nx = S_FIN;
      end
      // Engine stays in run so its result is still on q when the buffer writes.
      S_STORE: begin
        dot_run  = 1'b1;
        cnt_load = 1'b0;
        out_we   = 1'b1;
        if (d_row == RW'(ROWS - 1)) state_nx = S_FIN;
        else begin
          row_inc  = 1'b1;
          state_nx = S_GAP;
        end
      end
      S_GAP: state_nx = S_PREFETCH;
      S_FIN: begin
        done     = 1'b1;
        row_clr  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign out_addr = d_row;

  mix_ctrl_addr #(
    .HID_DIM(HID_DIM), .CHUNKS(CHUNKS), .BIAS_CAP0(BIAS_CAP0), .TMO_CYC(TMO_CYC)
  ) u_addr (
    .clk(clk), .rst_n(rst_n), .load(cnt_load), .en(state == S_RUN),
    .addr_w(addr_w), .seg_sel(seg_sel), .addr_b(addr_b), .tmo(tmo)
  );

`ifdef MIX_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err <= 1'b0;
    else if (state == S_RUN && !dot_valid && tmo)   err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule
